nibble_serial_add_seq: RTL

Sequencer that performs WIDTH-bit addition by streaming 4-bit nibble slices through an external 4-bit ripple-carry adder, one nibble per clock, LSB first. It registers operands, drives the adder inputs and chains the adder carry-out back as the next carry-in. It collects the sum nibbles and presents the full result through a valid/ready handshake. It sits directly upstream and downstream of the 4-bit adder, which is wired to its add_* ports at the parent level.

---
 rtl/nibble_serial_add_seq.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/nibble_serial_add_seq.sv
// Streams a WIDTH-bit addition through an external 4-bit adder one nibble per
// clock, LSB first, and presents the assembled sum over a valid/ready handshake.
module nibble_serial_add_seq #(
  parameter  int WIDTH = 16,
  localparam int NIB   = WIDTH / 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_cin,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_cin,
  input  logic [3:0]       add_sum,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

  if (((WIDTH % 4) != 0) || (WIDTH < 4)) begin : g_bad_width
    $error("nibble_serial_add_seq: WIDTH must be a multiple of 4 and >= 4");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               cy_q, cy_d;
  logic               carry_q, carry_d;
  logic               last_s;
  logic [IDX_W+1:0]   base_s;

  assign last_s = (idx_q == IDX_W'(NIB - 1));
  assign base_s = {idx_q, 2'b00};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cy_q     <= 1'b0;
      carry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      cy_q     <= cy_d;
      carry_q  <= carry_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    cy_d     = cy_q;
    carry_d  = carry_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = op_a;
          b_d     = op_b;
          cy_d    = op_cin;
          idx_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        // The adder answer for the current slice lands directly in the result.
        result_d[base_s +: 4] = add_sum;
        cy_d                  = add_cout;
        if (last_s) begin
          carry_d = add_cout;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    add_a     = 4'd0;
    add_b     = 4'd0;
    add_cin   = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
      end
      S_RUN: begin
        add_a   = a_q[base_s +: 4];
        add_b   = b_q[base_s +: 4];
        add_cin = cy_q;
      end
      S_DONE: begin
        out_valid = 1'b1;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  assign result = result_q;
  assign carry  = carry_q;

endmodule
